// File: rtl/z80_exec_if.sv
// Micro-op handshake bundle between the instruction sequencer and the execute stage.
interface z80_exec_if;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_op;
    logic [2:0] in_dst;
    logic [2:0] in_src;
    logic [7:0] in_imm;
    logic       in_use_imm;
    logic       in_wide;
    logic       in_wb;
    logic [7:0] in_fmask;

    modport master (
        output in_valid, in_op, in_dst, in_src, in_imm, in_use_imm, in_wide, in_wb, in_fmask,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_op, in_dst, in_src, in_imm, in_use_imm, in_wide, in_wb, in_fmask,
        output in_ready
    );
endinterface

// File: rtl/z80_exec.sv
// Z80-style execute stage: register file, flag register and a 3-cycle
// accept/execute/writeback sequencer around an external ALU.
//
// state  | meaning
// S_IDLE | ready for a micro-op; done pulses here after a writeback
// S_EXEC | operands on the ALU bus, ALU result captured at the closing edge
// S_WB   | captured result and flags committed at the closing edge
module z80_exec #(
    parameter logic [15:0] SP_RESET = 16'hFFFE
) (
    input  logic        clk,
    input  logic        rst_n,
    z80_exec_if.slave   uop,
    output logic [4:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_f,
    input  logic [15:0] alu_d,
    input  logic [3:0]  alu_nf,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    input  logic [1:0]  rd_pair_sel,
    output logic [15:0] rd_pair,
    output logic [3:0]  flags,
    output logic        done
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_regs [0:7];
    logic [15:0] r_sp;
    logic [3:0]  r_f;

    logic [2:0]  r_dst;
    logic        r_wide;
    logic        r_wb;
    logic [7:0]  r_fmask;
    logic [4:0]  r_alu_op;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [15:0] r_d;
    logic [3:0]  r_nf;
    logic        r_done;

    logic [7:0]  w_reg  [0:7];
    logic [15:0] w_pair [0:3];
    logic        w_accept;
    logic [15:0] w_opa;
    logic [15:0] w_opb;

    // Index 6 is the (HL) slot in the Z80 encoding; here it reads as zero.
    always_comb begin
        for (int i = 0; i < 8; i++) w_reg[i] = r_regs[i];
        w_reg[6] = 8'h00;
    end

    assign w_pair[0] = {r_regs[0], r_regs[1]};
    assign w_pair[1] = {r_regs[2], r_regs[3]};
    assign w_pair[2] = {r_regs[4], r_regs[5]};
    assign w_pair[3] = r_sp;

    assign uop.in_ready = (r_state == S_IDLE);
    assign w_accept     = uop.in_valid && (r_state == S_IDLE);

    // Registers cannot change between accept and EXEC, so operands are sampled at accept.
    assign w_opa = uop.in_wide ? w_pair[uop.in_dst[2:1]] : {8'h00, w_reg[uop.in_dst]};
    assign w_opb = uop.in_wide ? w_pair[uop.in_src[2:1]]
                               : {8'h00, (uop.in_use_imm ? uop.in_imm : w_reg[uop.in_src])};

    assign alu_op  = r_alu_op;
    assign alu_a   = r_alu_a;
    assign alu_b   = r_alu_b;
    assign alu_f   = r_f;
    assign rd_data = w_reg[rd_addr];
    assign rd_pair = w_pair[rd_pair_sel];
    assign flags   = r_f;
    assign done    = r_done;

    function automatic logic flag_next(input logic [1:0] mode, input logic cur,
                                       input logic alu, input logic alu_ok);
        case (mode)
            2'b00:   flag_next = cur;
            2'b01:   flag_next = alu_ok ? alu : cur;
            2'b10:   flag_next = 1'b0;
            default: flag_next = 1'b1;
        endcase
    endfunction

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (uop.in_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
            r_sp     <= SP_RESET;
            r_f      <= 4'h0;
            r_dst    <= 3'd0;
            r_wide   <= 1'b0;
            r_wb     <= 1'b0;
            r_fmask  <= 8'h00;
            r_alu_op <= 5'd0;
            r_alu_a  <= 16'h0000;
            r_alu_b  <= 16'h0000;
            r_d      <= 16'h0000;
            r_nf     <= 4'h0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WB);
            if (w_accept) begin
                r_dst    <= uop.in_dst;
                r_wide   <= uop.in_wide;
                r_wb     <= uop.in_wb;
                r_fmask  <= uop.in_fmask;
                r_alu_op <= uop.in_op;
                r_alu_a  <= w_opa;
                r_alu_b  <= w_opb;
            end
            if (r_state == S_EXEC) begin
                r_d  <= alu_d;
                r_nf <= alu_nf;
            end
            if (r_state == S_WB) begin
                if (r_wb) begin
                    if (r_wide) begin
                        case (r_dst[2:1])
                            2'd0: begin r_regs[0] <= r_d[15:8]; r_regs[1] <= r_d[7:0]; end
                            2'd1: begin r_regs[2] <= r_d[15:8]; r_regs[3] <= r_d[7:0]; end
                            2'd2: begin r_regs[4] <= r_d[15:8]; r_regs[5] <= r_d[7:0]; end
                            default: r_sp <= r_d;
                        endcase
                    end else if (r_dst != 3'd6) begin
                        r_regs[r_dst] <= r_d[7:0];
                    end
                end
                // N never takes the ALU value: mode 01 on N acts as keep.
                r_f[3] <= flag_next(r_fmask[7:6], r_f[3], r_nf[3], 1'b1);
                r_f[2] <= flag_next(r_fmask[5:4], r_f[2], r_nf[2], 1'b0);
                r_f[1] <= flag_next(r_fmask[3:2], r_f[1], r_nf[1], 1'b1);
                r_f[0] <= flag_next(r_fmask[1:0], r_f[0], r_nf[0], 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_z80_exec.sv
// Directed bench for z80_exec: table of micro-ops with hand-computed results,
// plus back-to-back and reset-abort sequences. A small ALU model sits on the ALU port.
module tb_z80_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  alu_op;
    logic [15:0] alu_a, alu_b, alu_d;
    logic [3:0]  alu_f, alu_nf;
    logic [2:0]  rd_addr = 3'd0;
    logic [7:0]  rd_data;
    logic [1:0]  rd_pair_sel = 2'd0;
    logic [15:0] rd_pair;
    logic [3:0]  flags;
    logic        done;

    int n_pass = 0;
    int n_total = 0;

    z80_exec_if uop();

    z80_exec #(.SP_RESET(16'hFFFE)) dut (
        .clk(clk), .rst_n(rst_n), .uop(uop),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_d(alu_d), .alu_nf(alu_nf),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pair_sel(rd_pair_sel), .rd_pair(rd_pair),
        .flags(flags), .done(done)
    );

    always #5 clk = ~clk;

    // ALU model: 0 = LD (pass b), 4 = ADD16, 5 = ADD8, 7 = SUB8
    logic [16:0] s17;
    logic [12:0] s13;
    logic [8:0]  s9;
    logic [4:0]  s5;
    always_comb begin
        alu_d  = 16'h0000;
        alu_nf = 4'h0;
        s17    = {1'b0, alu_a} + {1'b0, alu_b};
        s13    = {1'b0, alu_a[11:0]} + {1'b0, alu_b[11:0]};
        s9     = {1'b0, alu_a[7:0]} + {1'b0, alu_b[7:0]};
        s5     = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]};
        case (alu_op)
            5'h00: begin alu_d = alu_b; alu_nf = alu_f; end
            5'h04: begin alu_d = s17[15:0]; alu_nf = {alu_f[3], 1'b0, s13[12], s17[16]}; end
            5'h05: begin alu_d = {8'h00, s9[7:0]}; alu_nf = {(s9[7:0] == 8'h00), 1'b0, s5[4], s9[8]}; end
            5'h07: begin
                alu_d  = {8'h00, alu_a[7:0] - alu_b[7:0]};
                alu_nf = {(alu_a[7:0] == alu_b[7:0]), 1'b1, (alu_a[3:0] < alu_b[3:0]), (alu_a[7:0] < alu_b[7:0])};
            end
            default: begin alu_d = 16'h0000; alu_nf = 4'h0; end
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] src,
                         input logic [7:0] imm, input logic ui, input logic wide,
                         input logic wb, input logic [7:0] fm);
        uop.in_op = op; uop.in_dst = dst; uop.in_src = src; uop.in_imm = imm;
        uop.in_use_imm = ui; uop.in_wide = wide; uop.in_wb = wb; uop.in_fmask = fm;
    endtask

    typedef struct packed {
        logic [4:0]  op;
        logic [2:0]  dst;
        logic [2:0]  src;
        logic [7:0]  imm;
        logic        ui;
        logic        wide;
        logic        wb;
        logic [7:0]  fm;
        logic        pair_chk;
        logic [2:0]  idx;
        logic [15:0] exp_val;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t vecs [0:15];
    int   lat;
    int   d1, d2, ndone;
    logic drop;

    initial begin
        //                op     dst   src   imm    ui    wide  wb    fmask  pair  idx   value      flags
        vecs[0]  = '{5'h00, 3'd7, 3'd0, 8'h3A, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd7, 16'h003A, 4'h0};
        vecs[1]  = '{5'h05, 3'd7, 3'd0, 8'hC6, 1'b1, 1'b0, 1'b1, 8'h65, 1'b0, 3'd7, 16'h0000, 4'hB};
        vecs[2]  = '{5'h00, 3'd7, 3'd0, 8'h10, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd7, 16'h0010, 4'hB};
        vecs[3]  = '{5'h00, 3'd0, 3'd0, 8'h20, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0020, 4'hB};
        vecs[4]  = '{5'h07, 3'd7, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h75, 1'b0, 3'd7, 16'h0010, 4'h5};
        vecs[5]  = '{5'h00, 3'd4, 3'd0, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd4, 16'h000F, 4'h5};
        vecs[6]  = '{5'h00, 3'd5, 3'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd5, 16'h00FF, 4'h5};
        vecs[7]  = '{5'h00, 3'd0, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 16'h0000, 4'h5};
        vecs[8]  = '{5'h00, 3'd1, 3'd0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd1, 16'h0001, 4'h5};
        vecs[9]  = '{5'h04, 3'd4, 3'd0, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h25, 1'b1, 3'd2, 16'h1000, 4'h2};
        vecs[10] = '{5'h00, 3'd6, 3'd4, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 3'd3, 16'h1000, 4'h2};
        vecs[11] = '{5'h00, 3'd6, 3'd0, 8'h55, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 3'd6, 16'h0000, 4'hF};
        vecs[12] = '{5'h00, 3'd2, 3'd0, 8'h77, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 3'd2, 16'h0077, 4'hF};
        vecs[13] = '{5'h00, 3'd2, 3'd6, 8'h99, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 3'd2, 16'h0000, 4'h7};
        vecs[14] = '{5'h00, 3'd3, 3'd7, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 3'd3, 16'h0010, 4'h7};
        vecs[15] = '{5'h05, 3'd7, 3'd0, 8'hF0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 3'd7, 16'h0000, 4'hD};

        uop.in_valid = 1'b0;
        drive(5'h00, 3'd0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("reset_reg%0d", i), {8'h00, rd_data}, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            rd_pair_sel = 2'(i);
            #1;
            check($sformatf("reset_pair%0d", i), rd_pair, (i == 3) ? 16'hFFFE : 16'h0000);
        end
        check("reset_flags", {12'h000, flags}, 16'h0000);
        check("reset_ready", {15'h0, uop.in_ready}, 16'h0001);
        check("reset_done", {15'h0, done}, 16'h0000);
        check("reset_alu_a", alu_a, 16'h0000);

        // Table of single micro-ops
        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            drive(vecs[v].op, vecs[v].dst, vecs[v].src, vecs[v].imm, vecs[v].ui,
                  vecs[v].wide, vecs[v].wb, vecs[v].fm);
            uop.in_valid = 1'b1;
            @(posedge clk);
            #1;
            uop.in_valid = 1'b0;
            lat = 0;
            while (!done && lat < 6) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check($sformatf("v%0d_latency", v), 16'(lat), 16'd2);
            rd_addr = vecs[v].idx;
            rd_pair_sel = vecs[v].idx[1:0];
            #1;
            if (vecs[v].pair_chk) check($sformatf("v%0d_pair", v), rd_pair, vecs[v].exp_val);
            else                  check($sformatf("v%0d_reg", v), {8'h00, rd_data}, vecs[v].exp_val);
            check($sformatf("v%0d_flags", v), {12'h000, flags}, {12'h000, vecs[v].exp_f});
            check($sformatf("v%0d_alu_f", v), {12'h000, alu_f}, {12'h000, vecs[v].exp_f});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", v), {15'h0, done}, 16'h0000);
        end

        // ALU operand bus holds the last op (ADD A,F0 with A=10)
        check("hold_alu_op", {11'h0, alu_op}, 16'h0005);
        check("hold_alu_a", alu_a, 16'h0010);
        check("hold_alu_b", alu_b, 16'h00F0);

        // Back-to-back: in_valid held high across two ops
        @(negedge clk);
        drive(5'h00, 3'd1, 3'd0, 8'h11, 1'b1, 1'b0, 1'b1, 8'h00);
        uop.in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(5'h00, 3'd2, 3'd0, 8'h22, 1'b1, 1'b0, 1'b1, 8'h00);
        d1 = -1; d2 = -1; ndone = 0; drop = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (drop) begin uop.in_valid = 1'b0; drop = 1'b0; end
            if (k == 1) check("b2b_busy_not_ready", {15'h0, uop.in_ready}, 16'h0000);
            if (done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = k;
                    drop = 1'b1;
                    check("b2b_ready_in_done", {15'h0, uop.in_ready}, 16'h0001);
                end else if (d2 < 0) d2 = k;
            end
        end
        check("b2b_first_done", 16'(d1), 16'd2);
        check("b2b_second_done", 16'(d2), 16'd5);
        check("b2b_done_count", 16'(ndone), 16'd2);
        rd_addr = 3'd1; #1;
        check("b2b_C", {8'h00, rd_data}, 16'h0011);
        rd_addr = 3'd2; #1;
        check("b2b_D", {8'h00, rd_data}, 16'h0022);

        // Reset mid-EXEC of a write to A
        @(negedge clk);
        drive(5'h00, 3'd7, 3'd0, 8'h99, 1'b1, 1'b0, 1'b1, 8'hFF);
        uop.in_valid = 1'b1;
        @(posedge clk);
        #1;
        uop.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_ready", {15'h0, uop.in_ready}, 16'h0001);
        rd_pair_sel = 2'd3; #1;
        check("rst_exec_sp", rd_pair, 16'hFFFE);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_exec_no_done", 16'(ndone), 16'd0);
        rd_addr = 3'd7; #1;
        check("rst_exec_A", {8'h00, rd_data}, 16'h0000);
        check("rst_exec_flags", {12'h000, flags}, 16'h0000);

        // Reset during WB of a write to B
        @(negedge clk);
        drive(5'h00, 3'd0, 3'd0, 8'h5A, 1'b1, 1'b0, 1'b1, 8'hFF);
        uop.in_valid = 1'b1;
        @(posedge clk);
        #1;
        uop.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("rst_wb_no_done", 16'(ndone), 16'd0);
        rd_addr = 3'd0; #1;
        check("rst_wb_B", {8'h00, rd_data}, 16'h0000);
        check("rst_wb_flags", {12'h000, flags}, 16'h0000);
        check("rst_wb_ready", {15'h0, uop.in_ready}, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
